// File: rtl/helix_pkg.sv
// Shared types and defaults for the helix feedback path.
package helix_pkg;

  localparam int FEEDBACK_W   = 16;
  localparam int INTEG_ACC_W  = 16;
  localparam int INTEG_THRESH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    ALERT   = 2'd2,
    HOLDOFF = 2'd3
  } integ_state_t;

endpackage

// File: rtl/helix_popcount.sv
// Combinational population count of a W-bit word.
module helix_popcount #(
  parameter  int W  = 16,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/helix_feedback_integrator.sv
// Leaky saturating mismatch integrator: raises one correction request per threshold
// crossing, stalls feedback until it is acknowledged, then ignores input for a holdoff.
module helix_feedback_integrator #(
  parameter int FEEDBACK_W  = helix_pkg::FEEDBACK_W,
  parameter int ACC_W       = helix_pkg::INTEG_ACC_W,
  parameter int LEAK_SHIFT  = 3,
  parameter int THRESH      = helix_pkg::INTEG_THRESH,
  parameter int HOLDOFF_CYC = 8,
  parameter int WINDOW      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  feedback_valid,
  output logic                  feedback_ready,
  input  logic [FEEDBACK_W-1:0] feedback_delta,
  input  logic                  cfg_clear,
  output logic                  corr_valid,
  input  logic                  corr_ready,
  output logic [ACC_W-1:0]      corr_magnitude,
  output logic [FEEDBACK_W-1:0] corr_mask,
  output logic [ACC_W-1:0]      err_level,
  output logic [1:0]            state_o
);
  import helix_pkg::*;

  localparam int PC_W   = $clog2(FEEDBACK_W + 1);
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

  if (THRESH < 1 || longint'(THRESH) > ((longint'(1) << ACC_W) - 1)) begin : g_bad_thresh
    $error("THRESH must lie in 1 .. 2**ACC_W-1");
  end
  if (HOLDOFF_CYC < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYC must be at least 1");
  end
  if (WINDOW < 1 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("WINDOW must be a power of two");
  end

  integ_state_t          state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FEEDBACK_W-1:0] mask_q, mask_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  corr_valid_q, corr_valid_d;
  logic [ACC_W-1:0]      corr_mag_q, corr_mag_d;
  logic [FEEDBACK_W-1:0] corr_mask_q, corr_mask_d;

  logic [PC_W-1:0]       pc;
  logic [ACC_W-1:0]      leak, acc_next;
  logic [ACC_W:0]        sum;
  logic [FEEDBACK_W-1:0] mask_next;
  logic                  beat_acc, alert, win_last;

  helix_popcount #(.W(FEEDBACK_W)) u_popcount (
    .data_i  (feedback_delta),
    .count_o (pc)
  );

  // The leak never exceeds acc, so the extra MSB of sum only ever signals overflow.
  always_comb begin
    leak = acc_q >> LEAK_SHIFT;
    if (acc_q == '0) begin
      leak = '0;
    end else if (leak == '0) begin
      leak = ACC_W'(1);
    end
    sum       = {1'b0, acc_q} - {1'b0, leak} + (ACC_W+1)'(pc);
    acc_next  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    mask_next = mask_q | feedback_delta;
  end

  assign beat_acc = feedback_valid & feedback_ready;
  assign alert    = acc_next >= ACC_W'(THRESH);
  assign win_last = win_q == WIN_W'(WINDOW - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mask_q       <= '0;
      win_q        <= '0;
      hold_q       <= '0;
      corr_valid_q <= 1'b0;
      corr_mag_q   <= '0;
      corr_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      win_q        <= win_d;
      hold_q       <= hold_d;
      corr_valid_q <= corr_valid_d;
      corr_mag_q   <= corr_mag_d;
      corr_mask_q  <= corr_mask_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mask_d       = mask_q;
    win_d        = win_q;
    hold_d       = hold_q;
    corr_valid_d = corr_valid_q;
    corr_mag_d   = corr_mag_q;
    corr_mask_d  = corr_mask_q;
    if (cfg_clear) begin
      state_d      = IDLE;
      acc_d        = '0;
      mask_d       = '0;
      win_d        = '0;
      hold_d       = '0;
      corr_valid_d = 1'b0;
      corr_mag_d   = '0;
      corr_mask_d  = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat_acc) begin
            acc_d = acc_next;
            if (alert) begin
              // Alert wins over the window wrap so the request carries the full mask.
              state_d      = ALERT;
              mask_d       = mask_next;
              corr_valid_d = 1'b1;
              corr_mag_d   = acc_next;
              corr_mask_d  = mask_next;
            end else begin
              state_d = (acc_next == '0) ? IDLE : ACCUM;
              mask_d  = win_last ? '0 : mask_next;
              win_d   = win_last ? '0 : win_q + WIN_W'(1);
            end
          end
        end
        ALERT: begin
          if (corr_valid_q && corr_ready) begin
            state_d      = HOLDOFF;
            corr_valid_d = 1'b0;
            acc_d        = '0;
            mask_d       = '0;
            win_d        = '0;
            hold_d       = HOLD_W'(HOLDOFF_CYC);
          end
        end
        HOLDOFF: begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    feedback_ready = (state_q != ALERT);
    corr_valid     = corr_valid_q;
    corr_magnitude = corr_mag_q;
    corr_mask      = corr_mask_q;
    err_level      = acc_q;
    state_o        = state_q;
  end

endmodule

// File: tb/tb_helix_feedback_integrator.sv
// Directed scoreboard bench for the feedback integrator; a second instance with an
// 8-bit accumulator exercises saturation.
module tb_helix_feedback_integrator;
  import helix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fb_valid, fb_ready, cfg_clear, corr_valid, corr_ready;
  logic [15:0] fb_delta, corr_mag, corr_mask, err_level;
  logic [1:0]  state;

  logic        s_valid, s_ready, s_clear, s_cv, s_cr;
  logic [15:0] s_delta, s_mask;
  logic [7:0]  s_mag, s_err;
  logic [1:0]  s_state;

  helix_feedback_integrator dut (
    .clk(clk), .rst_n(rst_n),
    .feedback_valid(fb_valid), .feedback_ready(fb_ready), .feedback_delta(fb_delta),
    .cfg_clear(cfg_clear),
    .corr_valid(corr_valid), .corr_ready(corr_ready),
    .corr_magnitude(corr_mag), .corr_mask(corr_mask),
    .err_level(err_level), .state_o(state)
  );

  // A shallower leak lets 16-bit beats outrun it and drive the 8-bit accumulator into clamp.
  helix_feedback_integrator #(.ACC_W(8), .THRESH(255), .LEAK_SHIFT(5)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .feedback_valid(s_valid), .feedback_ready(s_ready), .feedback_delta(s_delta),
    .cfg_clear(s_clear),
    .corr_valid(s_cv), .corr_ready(s_cr),
    .corr_magnitude(s_mag), .corr_mask(s_mask),
    .err_level(s_err), .state_o(s_state)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_q[$];
  int          m_acc, m_win, s_acc;
  logic [15:0] m_mask, m_corr_mask;
  logic        m_alert, s_alert;

  function automatic int leak_step(input int acc, input int pc, input int accw, input int sh);
    int leak, s, mx;
    mx   = (1 << accw) - 1;
    leak = (acc == 0) ? 0 : (((acc >> sh) == 0) ? 1 : (acc >> sh));
    s    = acc - leak + pc;
    if (s > mx) s = mx;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_acc = 0; m_win = 0; m_mask = '0; m_alert = 1'b0;
  endtask

  // One accepted beat on the main instance; expected level is queued at drive time.
  task automatic beat(input logic [15:0] d);
    logic [15:0] mnext;
    fb_valid = 1'b1;
    fb_delta = d;
    mnext    = m_mask | d;
    m_acc    = leak_step(m_acc, $countones(d), 16, 3);
    m_alert  = (m_acc >= 64);
    if (m_alert) begin
      m_corr_mask = mnext;
      m_mask      = mnext;
    end else begin
      m_mask = (m_win == 31) ? 16'h0000 : mnext;
      m_win  = (m_win + 1) % 32;
    end
    exp_q.push_back(m_acc);
    cyc();
    fb_valid = 1'b0;
    $display("beat delta=0x%04h err_level=%0d corr_valid=%0b state=%0d", d, err_level, corr_valid, state);
    chk("err_level", 32'(err_level), 32'(exp_q.pop_front()));
    chk("corr_valid", 32'(corr_valid), 32'(m_alert));
    chk("state", 32'(state), m_alert ? 32'(ALERT) : ((m_acc == 0) ? 32'(IDLE) : 32'(ACCUM)));
    if (m_alert) begin
      chk("corr_magnitude", 32'(corr_mag), 32'(m_acc));
      chk("corr_mask", 32'(corr_mask), 32'(m_corr_mask));
    end
  endtask

  task automatic s_beat(input logic [15:0] d);
    s_valid = 1'b1;
    s_delta = d;
    s_acc   = leak_step(s_acc, $countones(d), 8, 5);
    s_alert = (s_acc >= 255);
    exp_q.push_back(s_acc);
    cyc();
    s_valid = 1'b0;
    $display("sat beat delta=0x%04h err_level=%0d corr_valid=%0b", d, s_err, s_cv);
    chk("sat_err_level", 32'(s_err), 32'(exp_q.pop_front()));
    chk("sat_corr_valid", 32'(s_cv), 32'(s_alert));
  endtask

  task automatic ack_and_drain();
    corr_ready = 1'b1;
    cyc();
    corr_ready = 1'b0;
    model_reset();
    chk("ack_state", 32'(state), 32'(HOLDOFF));
    chk("ack_corr_valid", 32'(corr_valid), 32'd0);
    chk("ack_err_level", 32'(err_level), 32'd0);
    for (int i = 0; i < 8; i++) cyc();
    chk("holdoff_exit", 32'(state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl2[5];
    int lvl4[4];
    lvl2 = '{16, 30, 43, 54, 64};
    lvl4 = '{3, 2, 1, 0};
    rst_n = 1'b0;
    fb_valid = 1'b0; fb_delta = '0; cfg_clear = 1'b0; corr_ready = 1'b0;
    s_valid = 1'b0; s_delta = '0; s_clear = 1'b0; s_cr = 1'b0;
    model_reset();
    s_acc = 0; s_alert = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_err_level", 32'(err_level), 32'd0);
    chk("rst_corr_valid", 32'(corr_valid), 32'd0);
    chk("rst_corr_magnitude", 32'(corr_mag), 32'd0);
    chk("rst_corr_mask", 32'(corr_mask), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_ready", 32'(fb_ready), 32'd1);
    chk("rst_sat_err", 32'(s_err), 32'd0);

    // Five all-ones beats climb to the threshold.
    for (int i = 0; i < 5; i++) begin
      beat(16'hFFFF);
      chk("ramp_level", 32'(err_level), 32'(lvl2[i]));
    end
    chk("alert_magnitude", 32'(corr_mag), 32'd64);
    chk("alert_mask", 32'(corr_mask), 32'hFFFF);
    chk("alert_ready", 32'(fb_ready), 32'd0);

    // Request held while corr_ready stays low; offered beats must not be taken.
    fb_valid = 1'b1; fb_delta = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_corr_valid", 32'(corr_valid), 32'd1);
      chk("hold_magnitude", 32'(corr_mag), 32'd64);
      chk("hold_mask", 32'(corr_mask), 32'hFFFF);
      chk("hold_err_level", 32'(err_level), 32'd64);
      chk("hold_ready", 32'(fb_ready), 32'd0);
    end
    corr_ready = 1'b1;
    cyc();
    corr_ready = 1'b0;
    model_reset();
    chk("ack_state", 32'(state), 32'(HOLDOFF));
    chk("ack_corr_valid", 32'(corr_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("holdoff_err_level", 32'(err_level), 32'd0);
      chk("holdoff_state", 32'(state), (i < 7) ? 32'(HOLDOFF) : 32'(IDLE));
      chk("holdoff_ready", 32'(fb_ready), 32'd1);
    end
    fb_valid = 1'b0;

    // Decay to zero after a single small beat.
    beat(16'h000F);
    chk("decay_start", 32'(err_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      beat(16'h0000);
      chk("decay_level", 32'(err_level), 32'(lvl4[i]));
    end

    // Clear while a request is pending.
    for (int i = 0; i < 5; i++) beat(16'hFFFF);
    cfg_clear = 1'b1; fb_valid = 1'b1; fb_delta = 16'hFFFF;
    cyc();
    cfg_clear = 1'b0; fb_valid = 1'b0;
    model_reset();
    chk("clr_corr_valid", 32'(corr_valid), 32'd0);
    chk("clr_state", 32'(state), 32'(IDLE));
    chk("clr_ready", 32'(fb_ready), 32'd1);
    chk("clr_err_level", 32'(err_level), 32'd0);
    cfg_clear = 1'b1; fb_valid = 1'b1; fb_delta = 16'hFFFF;
    cyc();
    cfg_clear = 1'b0; fb_valid = 1'b0;
    chk("clr_beat_discard", 32'(err_level), 32'd0);

    // One full window of low-bit beats, then the mask must restart.
    for (int i = 0; i < 32; i++) beat(16'h0001);
    for (int i = 0; i < 100 && !m_alert; i++) beat(16'hFF00);
    chk("win_alert", 32'(corr_valid), 32'd1);
    chk("win_mask", 32'(corr_mask), 32'hFF00);
    ack_and_drain();

    // Saturation on the 8-bit instance.
    for (int i = 0; i < 100 && !s_alert; i++) s_beat(16'hFFFF);
    chk("sat_alert", 32'(s_cv), 32'd1);
    chk("sat_magnitude", 32'(s_mag), 32'd255);
    chk("sat_mask", 32'(s_mask), 32'hFFFF);
    chk("sat_ready", 32'(s_ready), 32'd0);

    // Asynchronous reset in the middle of activity.
    beat(16'hFFFF);
    beat(16'hFFFF);
    fb_valid = 1'b1; fb_delta = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1;
    chk("async_err_level", 32'(err_level), 32'd0);
    chk("async_state", 32'(state), 32'(IDLE));
    chk("async_sat_corr_valid", 32'(s_cv), 32'd0);
    chk("async_sat_magnitude", 32'(s_mag), 32'd0);
    fb_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    cyc();
    chk("post_rst_ready", 32'(fb_ready), 32'd1);
    chk("post_rst_err_level", 32'(err_level), 32'd0);
    chk("post_rst_corr_mask", 32'(corr_mask), 32'd0);
    chk("post_rst_sat_ready", 32'(s_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
